// File: rtl/eos_sched.sv
// Egress output scheduler: four strict-priority packet-ID FIFOs, one packet in flight at a time,
// with a per-window packet budget on best-effort queue 3 (over-budget packets issue with discard set).
module eos_sched #(
  parameter int QDEPTH         = 16,
  parameter int WINDOW_CYCLES  = 1000,
  parameter int BE_MAX_PKTS    = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  in_eos_md,
  input  logic        in_eos_md_wr,
  input  logic        in_eos_pkt_done,
  output logic [7:0]  out_eos_md,
  output logic        out_eos_md_wr,
  output logic        out_eos_bandwidth_discard,
  output logic [3:0]  out_eos_q_empty,
  output logic [15:0] out_eos_drop_cnt,
  output logic [15:0] out_eos_timeout_cnt
);
  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;
  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;

  logic [7:0]    mem [4][QDEPTH];
  logic [PW-1:0] wr_ptr [4];
  logic [PW-1:0] rd_ptr [4];
  logic [3:0]    empty, full;
  logic [1:0]    enq_q, sel;
  logic          enq_ok, drop, pop, wrap, tmo_inc;
  logic [7:0]    head, credit_q, credit_d;
  logic [WW-1:0] wcnt;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [15:0]   drop_cnt, tmo_cnt;
  logic [7:0]    md_p0, md_p1;
  logic          disc_p0, disc_p1, vld_p0, vld_p1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    for (int q = 0; q < 4; q++) begin
      empty[q] = (wr_ptr[q] == rd_ptr[q]);
      full[q]  = (wr_ptr[q][AW] != rd_ptr[q][AW]) &&
                 (wr_ptr[q][AW-1:0] == rd_ptr[q][AW-1:0]);
    end
  end

  assign enq_q  = in_eos_md[9:8];
  assign enq_ok = in_eos_md_wr && !full[enq_q];
  assign drop   = in_eos_md_wr && full[enq_q];
  assign wrap   = (wcnt == WW'(WINDOW_CYCLES - 1));

  always_comb begin
    if (!empty[0])      sel = 2'd0;
    else if (!empty[1]) sel = 2'd1;
    else if (!empty[2]) sel = 2'd2;
    else                sel = 2'd3;
  end

  assign head = mem[sel][rd_ptr[sel][AW-1:0]];

  // Stage p0: pop decision and discard flag computed in the IDLE cycle
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    vld_p0   = 1'b0;
    md_p0    = '0;
    disc_p0  = 1'b0;
    tcnt_d   = tcnt_q;
    tmo_inc  = 1'b0;
    credit_d = wrap ? 8'(BE_MAX_PKTS) : credit_q;
    case (state_q)
      IDLE: begin
        if (empty != 4'hF) begin
          pop     = 1'b1;
          vld_p0  = 1'b1;
          md_p0   = head;
          state_d = ISSUE;
          if (sel == 2'd3) begin
            // A pop in the reload cycle spends the fresh window's budget.
            if (wrap)                credit_d = 8'(BE_MAX_PKTS - 1);
            else if (credit_q != '0) credit_d = credit_q - 8'd1;
            else                     disc_p0  = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        tcnt_d  = '0;
      end
      WAIT: begin
        if (in_eos_pkt_done) begin
          state_d = IDLE;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          tmo_inc = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq_ok) mem[enq_q][wr_ptr[enq_q][AW-1:0]] <= in_eos_md[7:0];
  end

  // Stage p1: issue registers driving the egress buffer manager
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      credit_q <= 8'(BE_MAX_PKTS);
      wcnt     <= '0;
      tcnt_q   <= '0;
      drop_cnt <= '0;
      tmo_cnt  <= '0;
      vld_p1   <= 1'b0;
      md_p1    <= '0;
      disc_p1  <= 1'b0;
      for (int q = 0; q < 4; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
      end
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      wcnt     <= wrap ? '0 : wcnt + WW'(1);
      tcnt_q   <= tcnt_d;
      vld_p1   <= vld_p0;
      md_p1    <= md_p0;
      disc_p1  <= disc_p0;
      if (drop)    drop_cnt <= sat_inc16(drop_cnt);
      if (tmo_inc) tmo_cnt  <= sat_inc16(tmo_cnt);
      for (int q = 0; q < 4; q++) begin
        if (enq_ok && enq_q == 2'(q)) wr_ptr[q] <= wr_ptr[q] + PW'(1);
        if (pop && sel == 2'(q))      rd_ptr[q] <= rd_ptr[q] + PW'(1);
      end
    end
  end

  assign out_eos_md                = md_p1;
  assign out_eos_md_wr             = vld_p1;
  assign out_eos_bandwidth_discard = disc_p1;
  assign out_eos_q_empty           = empty;
  assign out_eos_drop_cnt          = drop_cnt;
  assign out_eos_timeout_cnt       = tmo_cnt;

endmodule

// File: tb/tb_eos_sched.sv
// Bench for eos_sched: directed scenarios plus randomized traffic against a transaction-level model.
module tb_eos_sched;
  localparam int QD = 16;
  localparam int W  = 1000;
  localparam int BE = 2;
  localparam int T  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  in_eos_md = '0;
  logic        in_eos_md_wr = 1'b0;
  logic        in_eos_pkt_done = 1'b0;
  logic [7:0]  out_eos_md;
  logic        out_eos_md_wr;
  logic        out_eos_bandwidth_discard;
  logic [3:0]  out_eos_q_empty;
  logic [15:0] out_eos_drop_cnt;
  logic [15:0] out_eos_timeout_cnt;

  always #5 clk = ~clk;

  eos_sched #(.QDEPTH(QD), .WINDOW_CYCLES(W), .BE_MAX_PKTS(BE), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_eos_md(in_eos_md), .in_eos_md_wr(in_eos_md_wr), .in_eos_pkt_done(in_eos_pkt_done),
    .out_eos_md(out_eos_md), .out_eos_md_wr(out_eos_md_wr),
    .out_eos_bandwidth_discard(out_eos_bandwidth_discard),
    .out_eos_q_empty(out_eos_q_empty), .out_eos_drop_cnt(out_eos_drop_cnt),
    .out_eos_timeout_cnt(out_eos_timeout_cnt)
  );

  typedef struct {logic [7:0] id; int cyc;} ent_t;
  typedef struct {logic [7:0] id; logic disc; int cyc;} obs_t;

  ent_t mq [4][$];
  obs_t obs_q [$];
  int   cyc;
  int   idle_bad = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_drop = 0;
  int   exp_tmo = 0;
  int   cur_win = -1;
  int   win_cnt = 0;

  // Cycle index since reset release; equals the window position modulo W.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_eos_md_wr) begin
        obs_t o;
        o.id = out_eos_md; o.disc = out_eos_bandwidth_discard; o.cyc = cyc;
        obs_q.push_back(o);
      end else if (out_eos_md !== 8'h00 || out_eos_bandwidth_discard !== 1'b0) begin
        idle_bad <= idle_bad + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic enq(input int q, input logic [7:0] id);
    ent_t e;
    logic [1:0] q2;
    q2 = 2'(q);
    in_eos_md = {q2, id};
    in_eos_md_wr = 1'b1;
    if (mq[q].size() >= QD) exp_drop++;
    else begin e.id = id; e.cyc = cyc; mq[q].push_back(e); end
    tick();
    in_eos_md_wr = 1'b0;
  endtask

  task automatic serve(input int dly);
    repeat (dly) tick();
    in_eos_pkt_done = 1'b1;
    tick();
    in_eos_pkt_done = 1'b0;
  endtask

  task automatic get_issue(input int max, output obs_t o, output bit ok);
    int n;
    n = 0; ok = 1'b0; o.id = '0; o.disc = 1'b0; o.cyc = 0;
    while (!ok && n < max) begin
      if (obs_q.size() > 0) begin o = obs_q.pop_front(); ok = 1'b1; end
      else begin tick(); n++; end
    end
  endtask

  // Reference: an issue at cycle i pops the oldest entry of the highest-priority queue that
  // held an entry enqueued at or before i-2; queue 3 gets BE packets per window, where the
  // window of the pop cycle (i-1) is (i-1+1)/W so a pop in the wrap cycle counts toward the next.
  task automatic model_pop(input int i, output logic [7:0] id, output logic disc, output bit found);
    int win;
    found = 1'b0; id = '0; disc = 1'b0;
    for (int q = 0; q < 4; q++) begin
      if (!found && mq[q].size() > 0 && mq[q][0].cyc <= i - 2) begin
        found = 1'b1;
        id = mq[q][0].id;
        void'(mq[q].pop_front());
        if (q == 3) begin
          win = i / W;
          if (win != cur_win) begin cur_win = win; win_cnt = 0; end
          disc = (win_cnt >= BE);
          win_cnt++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_chk++; if (out_eos_md_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b want 0", out_eos_md_wr); end
    n_chk++; if (out_eos_md !== 8'h00) begin n_fail++; $display("FAIL reset_md got %h want 00", out_eos_md); end
    n_chk++; if (out_eos_bandwidth_discard !== 1'b0) begin n_fail++; $display("FAIL reset_disc got %b want 0", out_eos_bandwidth_discard); end
    n_chk++; if (out_eos_q_empty !== 4'hF) begin n_fail++; $display("FAIL reset_empty got %h want F", out_eos_q_empty); end
    n_chk++; if (out_eos_drop_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_drop got %h want 0", out_eos_drop_cnt); end
    n_chk++; if (out_eos_timeout_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_tmo got %h want 0", out_eos_timeout_cnt); end
    rst_n = 1'b1;
    repeat (3) tick();
    n_chk++; if (out_eos_md_wr !== 1'b0 || out_eos_q_empty !== 4'hF) begin
      n_fail++; $display("FAIL post_reset_idle got wr=%b empty=%h want wr=0 empty=F", out_eos_md_wr, out_eos_q_empty);
    end
  endtask

  task automatic test_single();
    obs_t o; bit ok, f; logic [7:0] eid; logic ed; int c, i, t;
    c = cyc;
    enq(1, 8'h23);
    get_issue(20, o, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL single_issue timed out"); return; end
    model_pop(o.cyc, eid, ed, f);
    if (o.cyc !== c + 2) begin n_fail++; $display("FAIL single_latency got cycle %0d want %0d", o.cyc, c + 2); end
    n_chk++; if (o.id !== eid || o.id !== 8'h23) begin n_fail++; $display("FAIL single_id got %h want 23", o.id); end
    n_chk++; if (o.disc !== 1'b0) begin n_fail++; $display("FAIL single_disc got %b want 0", o.disc); end
    i = o.cyc;
    enq(0, 8'h24);
    while (cyc < i + 5) tick();
    t = cyc;
    serve(0);
    get_issue(20, o, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL single_next timed out"); return; end
    model_pop(o.cyc, eid, ed, f);
    if (o.cyc !== t + 2) begin n_fail++; $display("FAIL single_next_gap got cycle %0d want %0d", o.cyc, t + 2); end
    n_chk++; if (o.id !== eid) begin n_fail++; $display("FAIL single_next_id got %h want %h", o.id, eid); end
    serve(0);
  endtask

  task automatic test_priority();
    obs_t o; bit ok, f; logic [7:0] eid; logic ed;
    logic [7:0] exp_ord [3];
    exp_ord[0] = 8'h01; exp_ord[1] = 8'h20; exp_ord[2] = 8'h30;
    enq(1, 8'h11);
    get_issue(20, o, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL prio_first timed out"); return; end
    model_pop(o.cyc, eid, ed, f);
    if (o.id !== eid) begin n_fail++; $display("FAIL prio_first_id got %h want %h", o.id, eid); end
    enq(3, 8'h30);
    enq(2, 8'h20);
    enq(0, 8'h01);
    serve(0);
    for (int k = 0; k < 3; k++) begin
      get_issue(20, o, ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL prio_order[%0d] timed out", k); return; end
      model_pop(o.cyc, eid, ed, f);
      if (o.id !== exp_ord[k] || o.id !== eid) begin n_fail++; $display("FAIL prio_order[%0d] got %h want %h", k, o.id, exp_ord[k]); end
      n_chk++; if (o.disc !== ed) begin n_fail++; $display("FAIL prio_disc[%0d] got %b want %b", k, o.disc, ed); end
      serve(1);
    end
  endtask

  task automatic test_rate();
    obs_t o; bit ok, f; logic [7:0] eid; logic ed;
    logic exp_disc [6];
    exp_disc[0] = 1'b0; exp_disc[1] = 1'b0; exp_disc[2] = 1'b1;
    exp_disc[3] = 1'b0; exp_disc[4] = 1'b0; exp_disc[5] = 1'b1;
    for (int n = 0; n < 2 * W && (cyc % W) != 10; n++) tick();
    enq(3, 8'h31); enq(3, 8'h32); enq(3, 8'h33);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        // Time the next pop onto the window-wrap cycle.
        for (int n = 0; n < 2 * W && (cyc % W) != W - 2; n++) tick();
        enq(3, 8'h34); enq(3, 8'h35); enq(3, 8'h36);
      end
      get_issue(20, o, ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL rate[%0d] timed out", k); return; end
      model_pop(o.cyc, eid, ed, f);
      if (o.disc !== exp_disc[k] || o.disc !== ed) begin
        n_fail++; $display("FAIL rate_disc[%0d] got %b want %b (cycle %0d)", k, o.disc, exp_disc[k], o.cyc);
      end
      n_chk++; if (o.id !== eid) begin n_fail++; $display("FAIL rate_id[%0d] got %h want %h", k, o.id, eid); end
      serve(1);
    end
  endtask

  task automatic test_full();
    obs_t o; bit ok, f; logic [7:0] eid; logic ed;
    enq(1, 8'h40);
    get_issue(20, o, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL full_stall timed out"); return; end
    model_pop(o.cyc, eid, ed, f);
    if (o.id !== eid) begin n_fail++; $display("FAIL full_stall_id got %h want %h", o.id, eid); end
    for (int k = 0; k < 17; k++) enq(2, 8'(8'h50 + k));
    n_chk++; if (out_eos_drop_cnt !== 16'(exp_drop) || out_eos_drop_cnt !== 16'd1) begin
      n_fail++; $display("FAIL full_drop_cnt got %0d want %0d", out_eos_drop_cnt, exp_drop);
    end
    n_chk++; if (out_eos_q_empty[2] !== 1'b0) begin n_fail++; $display("FAIL full_q2_empty got %b want 0", out_eos_q_empty[2]); end
    serve(0);
    for (int k = 0; k < 16; k++) begin
      get_issue(20, o, ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL full_drain[%0d] timed out", k); return; end
      model_pop(o.cyc, eid, ed, f);
      if (o.id !== eid || o.id !== 8'(8'h50 + k)) begin n_fail++; $display("FAIL full_drain[%0d] got %h want %h", k, o.id, eid); end
      serve(0);
    end
    tick();
    n_chk++; if (out_eos_q_empty !== 4'hF) begin n_fail++; $display("FAIL full_drained_empty got %h want F", out_eos_q_empty); end
  endtask

  task automatic test_timeout();
    obs_t o; bit ok, f; logic [7:0] eid; logic ed; int i;
    enq(1, 8'h70);
    enq(1, 8'h71);
    get_issue(20, o, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL tmo_first timed out"); return; end
    model_pop(o.cyc, eid, ed, f);
    if (o.id !== eid) begin n_fail++; $display("FAIL tmo_first_id got %h want %h", o.id, eid); end
    i = o.cyc;
    exp_tmo++;
    get_issue(T + 40, o, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL tmo_next timed out"); return; end
    model_pop(o.cyc, eid, ed, f);
    if (o.cyc !== i + T + 2) begin n_fail++; $display("FAIL tmo_next_cycle got %0d want %0d", o.cyc, i + T + 2); end
    n_chk++; if (o.id !== eid) begin n_fail++; $display("FAIL tmo_next_id got %h want %h", o.id, eid); end
    n_chk++; if (out_eos_timeout_cnt !== 16'(exp_tmo)) begin
      n_fail++; $display("FAIL tmo_cnt got %0d want %0d", out_eos_timeout_cnt, exp_tmo);
    end
    serve(0);
  endtask

  task automatic test_reset_wait();
    obs_t o; bit ok, f; logic [7:0] eid; logic ed; int c;
    enq(0, 8'h80);
    get_issue(20, o, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL rstw_first timed out"); return; end
    model_pop(o.cyc, eid, ed, f);
    if (o.id !== eid) begin n_fail++; $display("FAIL rstw_first_id got %h want %h", o.id, eid); end
    enq(1, 8'h81);
    rst_n = 1'b0;
    #1;
    n_chk++; if (out_eos_md_wr !== 1'b0 || out_eos_md !== 8'h00 || out_eos_bandwidth_discard !== 1'b0) begin
      n_fail++; $display("FAIL rstw_outputs got wr=%b md=%h disc=%b want 0", out_eos_md_wr, out_eos_md, out_eos_bandwidth_discard);
    end
    n_chk++; if (out_eos_q_empty !== 4'hF) begin n_fail++; $display("FAIL rstw_empty got %h want F", out_eos_q_empty); end
    n_chk++; if (out_eos_drop_cnt !== 16'h0 || out_eos_timeout_cnt !== 16'h0) begin
      n_fail++; $display("FAIL rstw_counters got drop=%0d tmo=%0d want 0", out_eos_drop_cnt, out_eos_timeout_cnt);
    end
    for (int q = 0; q < 4; q++) mq[q].delete();
    obs_q.delete();
    cur_win = -1; win_cnt = 0; exp_drop = 0; exp_tmo = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    c = cyc;
    enq(2, 8'h82);
    get_issue(20, o, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL rstw_new timed out"); return; end
    model_pop(o.cyc, eid, ed, f);
    if (o.id !== eid || o.id !== 8'h82) begin n_fail++; $display("FAIL rstw_new_id got %h want 82", o.id); end
    n_chk++; if (o.cyc !== c + 2) begin n_fail++; $display("FAIL rstw_new_latency got %0d want %0d", o.cyc, c + 2); end
    serve(0);
  endtask

  task automatic test_random();
    obs_t o; bit f, outst, fin; logic [7:0] eid; logic ed;
    int n_enq, dly, q;
    logic [7:0] id;
    ent_t e;
    n_enq = 0; outst = 1'b0; dly = 0; fin = 1'b0;
    for (int it = 0; it < 4000 && !fin; it++) begin
      if (n_enq < 40 && $urandom_range(0, 2) == 0) begin
        q = int'($urandom_range(0, 3));
        if (mq[q].size() < QD - 2) begin
          id = 8'($urandom);
          in_eos_md = {2'(q), id};
          in_eos_md_wr = 1'b1;
          e.id = id; e.cyc = cyc;
          mq[q].push_back(e);
          n_enq++;
        end
      end
      if (outst) begin
        if (dly == 0) begin in_eos_pkt_done = 1'b1; outst = 1'b0; end
        else dly--;
      end
      tick();
      in_eos_md_wr = 1'b0;
      in_eos_pkt_done = 1'b0;
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        model_pop(o.cyc, eid, ed, f);
        n_chk++; if (!f || o.id !== eid) begin n_fail++; $display("FAIL rand_id cycle %0d got %h want %h", o.cyc, o.id, eid); end
        n_chk++; if (o.disc !== ed) begin n_fail++; $display("FAIL rand_disc cycle %0d got %b want %b", o.cyc, o.disc, ed); end
        outst = 1'b1;
        dly = int'($urandom_range(0, 6));
      end
      if (n_enq == 40 && !outst && obs_q.size() == 0 &&
          mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0 && mq[3].size() == 0)
        fin = 1'b1;
    end
    n_chk++; if (!fin) begin n_fail++; $display("FAIL rand_drain did not complete, enq=%0d", n_enq); end
  endtask

  task automatic test_idle_outputs();
    n_chk++; if (idle_bad !== 0) begin n_fail++; $display("FAIL idle_outputs got %0d nonzero cycles want 0", idle_bad); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_rate();
    test_full();
    test_timeout();
    test_reset_wait();
    test_random();
    test_idle_outputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
